mux_stream_n: RTL and testbench
===============================

Name: mux_stream_n

Overview:
- Parametrised, registered successor to the fixed 4-input 32-bit datapath selector.
- Selects one of N valid/ready input channels and places its word in a single output register.
- Channel choice is either an explicit select (MODE=0) or round-robin arbitration (MODE=1).
- Sits between multi-source producers (writeback sources, bus masters) and a single consumer.

Parameters:
- WIDTH, 32, data width per channel.
- N, 4, channel count; legal range 2..16.
- MODE, 0, 0 = explicit select via sel; 1 = round-robin arbitration (sel ignored).
- SEL_W, $clog2(N), select/index width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- sel  in  SEL_W  channel select; used only when MODE=0.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; combinational.
- out_data  out  WIDTH  registered selected word.
- out_ch  out  SEL_W  index of the channel that produced out_data.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts the word.
- xfer_cnt  out  32  total accepted input transfers; wraps at 2^32.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_data=0, out_ch=0, xfer_cnt=0, round-robin pointer=0.
  - in_ready is all 0 while rst=1.
- load_en = !out_valid || out_ready. This is a single-stage pipeline with pass-through ready.
- Grant (combinational, one-hot or zero):
  - MODE=0: grant[sel] = in_valid[sel].
  - MODE=0, sel >= N: no grant, and all in_ready=0.
  - MODE=1: grant goes to the first channel with in_valid=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
- in_ready[i] = load_en && grant[i] && !rst. At most one in_ready is high per cycle.
- Transfer on channel g: in_valid[g] && in_ready[g] at a clock edge. On that edge:
  - out_data <= channel g word; out_ch <= g; out_valid <= 1.
  - xfer_cnt <= xfer_cnt+1.
  - MODE=1 only: ptr <= (g==N-1) ? 0 : g+1.
- No transfer, but out_valid && out_ready: out_valid <= 0. out_data and out_ch hold their last values.
- Simultaneous drain and load in the same cycle: the new word replaces the old one. out_valid stays 1, giving full throughput of one word per cycle.
- Stall (out_valid=1, out_ready=0):
  - out_data, out_ch and out_valid hold.
  - All in_ready=0.
  - ptr holds.
- Latency: input word appears on out_data exactly 1 cycle after its transfer edge.
- MODE=1, no in_valid asserted: no grant; ptr holds.
- MODE=0: sel is sampled every cycle. Changing sel while the output is stalled has no effect on the held word.
- Reset mid-operation: a held word is discarded (out_valid=0) and no transfer occurs on that edge.
- A channel with in_valid=1 and in_ready=0 must hold its data. The block makes no assumption about this and stores nothing on such a cycle.

Test Plan:
- Reset:
  - Stimulus: assert rst for 2 cycles with all in_valid=1.
  - Required: out_valid=0, out_data=0, xfer_cnt=0, in_ready=0 throughout; first transfer occurs on the first edge after rst deasserts.
- MODE=0 select:
  - Stimulus: N=4, WIDTH=32; in_data ch0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444, all valid, out_ready=1; sel=2, then sel=0.
  - Required: out_data=0x33333333 with out_ch=2 one cycle later, then 0x11111111 with out_ch=0; xfer_cnt=2.
- MODE=0 out-of-range:
  - Stimulus: N=3, sel=3, all valid.
  - Required: in_ready=000, out_valid stays 0, xfer_cnt unchanged.
- MODE=1 fairness:
  - Stimulus: N=4, all valid, out_ready=1 for 8 cycles.
  - Required: out_ch sequence 0,1,2,3,0,1,2,3; xfer_cnt=8.
- MODE=1 sparse:
  - Stimulus: only ch1 and ch3 valid.
  - Required: out_ch alternates 1,3,1,3.
  - Stimulus: after ch3, drop ch1 valid.
  - Required: ch3 is granted again.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with a word loaded.
  - Required: out_data and out_ch stable, in_ready=0, ptr frozen.
  - Stimulus: then raise out_ready.
  - Required: the next word lands in the same cycle the old one drains, with no bubble.

Source files
------------

// File: rtl/mux_stream_n.sv
// mux_stream_n: selects one of N valid/ready channels (explicit select or round-robin)
// into a single registered output stage with pass-through ready.
module mux_stream_n #(
   parameter  int WIDTH = 32,
   parameter  int N     = 4,
   parameter  int MODE  = 0,
   localparam int SEL_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [SEL_W-1:0]   sel,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_ch,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        xfer_cnt
);
   logic [WIDTH-1:0] data_q, data_d;
   logic [SEL_W-1:0] ch_q, ch_d, ptr_q, ptr_d, rr_idx, g_idx;
   logic [SEL_W:0]   c;
   logic [31:0]      cnt_q, cnt_d;
   logic             valid_q, valid_d, load_en, sel_hit, rr_hit, g_hit, xfer;

   assign sel_hit = ({1'b0, sel} < (SEL_W+1)'(N)) && in_valid[sel];

   // Scan channels starting at the pointer, wrapping past N-1 back to 0.
   always_comb begin
      rr_hit = 1'b0;
      rr_idx = '0;
      c      = '0;
      for (int i = 0; i < N; i++) begin
         c = {1'b0, ptr_q} + (SEL_W+1)'(i);
         if (c >= (SEL_W+1)'(N)) c = c - (SEL_W+1)'(N);
         if (!rr_hit && in_valid[c[SEL_W-1:0]]) begin
            rr_hit = 1'b1;
            rr_idx = c[SEL_W-1:0];
         end
      end
   end

   always_comb begin
      g_hit    = (MODE != 0) ? rr_hit : sel_hit;
      g_idx    = (MODE != 0) ? rr_idx : sel;
      load_en  = !valid_q || out_ready;
      xfer     = load_en && g_hit && !rst;
      in_ready = xfer ? (N'(1) << g_idx) : '0;
      data_d   = xfer ? in_data[g_idx*WIDTH +: WIDTH] : data_q;
      ch_d     = xfer ? g_idx : ch_q;
      valid_d  = xfer || (valid_q && !out_ready);
      cnt_d    = cnt_q + 32'(xfer);
      ptr_d    = ((MODE != 0) && xfer) ? ((g_idx == SEL_W'(N-1)) ? '0 : g_idx + 1'b1) : ptr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         ch_q    <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         data_q  <= data_d;
         ch_q    <= ch_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out_data  = data_q;
   assign out_ch    = ch_q;
   assign out_valid = valid_q;
   assign xfer_cnt  = cnt_q;
endmodule

// File: tb/tb_mux_stream_n.sv
// tb_mux_stream_n: three instances (N=4 select, N=3 select, N=4 round-robin)
// checked every cycle against a queue-free behavioural model plus literal expectations.
module tb_mux_stream_n;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [3:0]   valid [3];
   logic [127:0] data  [3];
   logic [1:0]   sel   [3];
   logic         ordy  [3];
   logic [3:0]   irdy  [3];
   logic [2:0]   irdy1;
   logic [31:0]  od    [3];
   logic [1:0]   och   [3];
   logic         ov    [3];
   logic [31:0]  cnt   [3];

   mux_stream_n #(.WIDTH(32), .N(4), .MODE(0)) u0 (
      .clk(clk), .rst(rst), .sel(sel[0]), .in_data(data[0]), .in_valid(valid[0]),
      .in_ready(irdy[0]), .out_data(od[0]), .out_ch(och[0]), .out_valid(ov[0]),
      .out_ready(ordy[0]), .xfer_cnt(cnt[0]));
   mux_stream_n #(.WIDTH(32), .N(3), .MODE(0)) u1 (
      .clk(clk), .rst(rst), .sel(sel[1]), .in_data(data[1][95:0]), .in_valid(valid[1][2:0]),
      .in_ready(irdy1), .out_data(od[1]), .out_ch(och[1]), .out_valid(ov[1]),
      .out_ready(ordy[1]), .xfer_cnt(cnt[1]));
   mux_stream_n #(.WIDTH(32), .N(4), .MODE(1)) u2 (
      .clk(clk), .rst(rst), .sel(sel[2]), .in_data(data[2]), .in_valid(valid[2]),
      .in_ready(irdy[2]), .out_data(od[2]), .out_ch(och[2]), .out_valid(ov[2]),
      .out_ready(ordy[2]), .xfer_cnt(cnt[2]));
   assign irdy[1] = {1'b0, irdy1};

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: what each output register must hold.
   bit          m_v   [3] = '{0, 0, 0};
   logic [31:0] m_d   [3] = '{0, 0, 0};
   int          m_ch  [3] = '{0, 0, 0};
   logic [31:0] m_cnt [3] = '{0, 0, 0};
   int          m_ptr [3] = '{0, 0, 0};

   function automatic int n_of(input int k);
      return (k == 1) ? 3 : 4;
   endfunction

   function automatic int pick(input int k);
      int n = n_of(k);
      int s = int'(sel[k]);
      if (k != 2) return (s < n && valid[k][s]) ? s : -1;
      for (int j = 0; j < n; j++)
         if (valid[k][(m_ptr[k] + j) % n]) return (m_ptr[k] + j) % n;
      return -1;
   endfunction

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         int g;
         bit ld;
         g  = pick(k);
         ld = !m_v[k] || ordy[k];
         check($sformatf("u%0d in_ready", k), 32'(irdy[k]), (!rst && ld && g >= 0) ? (32'd1 << g) : 32'd0);
         check($sformatf("u%0d out_valid", k), 32'(ov[k]), 32'(m_v[k]));
         check($sformatf("u%0d out_data", k), od[k], m_d[k]);
         check($sformatf("u%0d out_ch", k), 32'(och[k]), 32'(m_ch[k]));
         check($sformatf("u%0d xfer_cnt", k), cnt[k], m_cnt[k]);
         if (rst) begin
            m_v[k] = 0; m_d[k] = 0; m_ch[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0;
         end else if (ld && g >= 0) begin
            m_v[k]   = 1;
            m_d[k]   = data[k][g*32 +: 32];
            m_ch[k]  = g;
            m_cnt[k] = m_cnt[k] + 1;
            if (k == 2) m_ptr[k] = (g == n_of(k) - 1) ? 0 : g + 1;
         end else if (m_v[k] && ordy[k]) begin
            m_v[k] = 0;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         data[k]  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
         valid[k] = 4'hF;
         ordy[k]  = 1'b1;
         sel[k]   = 2'd0;
      end
      sel[0] = 2'd2;
      sel[1] = 2'd3;
      tick;
      tick;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst u%0d out_valid", k), 32'(ov[k]), 32'd0);
         check($sformatf("rst u%0d out_data", k), od[k], 32'd0);
         check($sformatf("rst u%0d xfer_cnt", k), cnt[k], 32'd0);
         check($sformatf("rst u%0d in_ready", k), 32'(irdy[k]), 32'd0);
      end
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick;
         if (i == 0) begin
            check("sel2 data", od[0], 32'h33333333);
            check("sel2 ch", 32'(och[0]), 32'd2);
            sel[0] = 2'd0;
         end
         if (i == 1) begin
            check("sel0 data", od[0], 32'h11111111);
            check("sel0 ch", 32'(och[0]), 32'd0);
            check("sel cnt", cnt[0], 32'd2);
            valid[0] = 4'h0;
         end
         check($sformatf("rr fair %0d", i), 32'(och[2]), 32'(i % 4));
      end
      check("rr fair cnt", cnt[2], 32'd8);
      check("oor cnt", cnt[1], 32'd0);
      check("oor valid", 32'(ov[1]), 32'd0);
      check("oor ready", 32'(irdy[1]), 32'd0);

      valid[2] = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         tick;
         check($sformatf("rr sparse %0d", i), 32'(och[2]), (i % 2) ? 32'd3 : 32'd1);
      end
      valid[2] = 4'b1000;
      tick;
      check("rr lone ch3", 32'(och[2]), 32'd3);
      check("rr sparse cnt", cnt[2], 32'd13);

      valid[0] = 4'hF;
      sel[0]   = 2'd1;
      valid[2] = 4'hF;
      ordy[2]  = 1'b0;
      tick;
      check("bp load", od[0], 32'h22222222);
      ordy[0] = 1'b0;
      sel[0]  = 2'd2;
      for (int i = 0; i < 3; i++) begin
         tick;
         check($sformatf("bp data %0d", i), od[0], 32'h22222222);
         check($sformatf("bp ch %0d", i), 32'(och[0]), 32'd1);
         check($sformatf("bp ready %0d", i), 32'(irdy[0]), 32'd0);
         check($sformatf("bp rr ch %0d", i), 32'(och[2]), 32'd3);
         check($sformatf("bp rr ready %0d", i), 32'(irdy[2]), 32'd0);
      end
      ordy[0] = 1'b1;
      ordy[2] = 1'b1;
      #1;
      check("bp release ready", 32'(irdy[0]), 32'b0100);
      check("bp release rr ready", 32'(irdy[2]), 32'b0001);
      tick;
      check("no bubble data", od[0], 32'h33333333);
      check("no bubble ch", 32'(och[0]), 32'd2);
      check("no bubble valid", 32'(ov[0]), 32'd1);
      check("no bubble cnt", cnt[0], 32'd4);
      check("rr ptr frozen", 32'(och[2]), 32'd0);
      check("rr bp cnt", cnt[2], 32'd14);

      ordy[0] = 1'b0;
      ordy[2] = 1'b0;
      tick;
      rst = 1'b1;
      tick;
      check("mid rst valid", 32'(ov[0]), 32'd0);
      check("mid rst cnt", cnt[2], 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         valid[k] = 4'h0;
         ordy[k]  = 1'b1;
      end
      tick;
      tick;
      tick;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
